// File: rtl/ioring_pkg.sv
// Shared types and helpers for the I/O ring scan controller.
package ioring_pkg;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

  // Width needed to hold values 0..value-1, never less than 1 bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/ioring_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module ioring_rr_arb
  import ioring_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  // Scan the request vector starting at the pointer; the first hit wins.
  always_comb begin
    logic found;
    int   idx;
    winner_onehot = '0;
    winner_idx    = '0;
    found         = 1'b0;
    idx           = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found              = 1'b1;
        winner_idx         = IDX_W'(idx);
        winner_onehot[idx] = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/ioring_scan_ctrl.sv
// I/O ring scan sequencer: arbitrates clients, runs capture/shift/update, returns the ring word.
module ioring_scan_ctrl
  import ioring_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int CLK_DIV    = 1,
  parameter int NUM_REQ    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*NUM_STAGES-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_STAGES-1:0]            rdata,
  output logic                             busy,
  output logic                             ring_load,
  output logic                             ring_shift,
  output logic                             ring_update,
  output logic                             ring_sdo,
  input  logic                             ring_sdi
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam int BIT_W = clog2(NUM_STAGES);
  localparam int IDX_W = clog2(NUM_REQ);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [BIT_W-1:0]        bit_reg, bit_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [IDX_W-1:0]        winner_reg, winner_next;
  logic [NUM_REQ-1:0]      winner_oh_reg, winner_oh_next;
  logic [NUM_STAGES-1:0]   sr_reg, sr_next;

  logic [NUM_REQ-1:0]      arb_onehot;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    tick;
  logic                    gnt_window;
  logic                    done_window;

  ioring_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req           (req),
    .ptr           (ptr_reg),
    .winner_onehot (arb_onehot),
    .winner_idx    (arb_idx),
    .any_req       (arb_any)
  );

  assign tick = (cnt_reg == CNT_W'(CLK_DIV - 1));

  // State and datapath registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      ptr_reg       <= '0;
      winner_reg    <= '0;
      winner_oh_reg <= '0;
      sr_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      ptr_reg       <= ptr_next;
      winner_reg    <= winner_next;
      winner_oh_reg <= winner_oh_next;
      sr_reg        <= sr_next;
    end
  end

  // Next-state logic: tick divider, arbitration, serial shifting and pointer advance.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = '0;
    bit_next       = bit_reg;
    ptr_next       = ptr_reg;
    winner_next    = winner_reg;
    winner_oh_next = winner_oh_reg;
    sr_next        = sr_reg;

    // The divider only runs while the ring is being driven.
    if (state_reg == CAPTURE || state_reg == SHIFT || state_reg == UPDATE) begin
      cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          sr_next        = wdata[int'(arb_idx)*NUM_STAGES +: NUM_STAGES];
          winner_next    = arb_idx;
          winner_oh_next = arb_onehot;
          state_next     = CAPTURE;
        end
      end
      CAPTURE: begin
        if (tick) begin
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sr_next = {ring_sdi, sr_reg[NUM_STAGES-1:1]};
          if (bit_reg == BIT_W'(NUM_STAGES - 1)) begin
            state_next = UPDATE;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      UPDATE: begin
        if (tick) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ptr_next   = (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + IDX_W'(1);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ring controls and status decoded purely from registered state.
  assign gnt_window  = (state_reg == CAPTURE) && (cnt_reg == '0);
  assign done_window = (state_reg == DONE);
  assign ring_load   = (state_reg == CAPTURE);
  assign ring_shift  = (state_reg == SHIFT);
  assign ring_update = (state_reg == UPDATE);
  assign ring_sdo    = ring_shift & sr_reg[0];
  assign busy        = (state_reg != IDLE);
  assign rdata       = sr_reg;

  // Per-client grant and completion pulses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
    assign gnt[gi]  = gnt_window  & winner_oh_reg[gi];
    assign done[gi] = done_window & winner_oh_reg[gi];
  end

endmodule
